// File: rtl/risc_cpu_pkg.sv
// Shared definitions for the small RISC CPU: bus widths, instruction field
// positions, memory map and the fetch sequencer state encoding.
package risc_cpu_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int IR_W   = 16;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 13;
    localparam int OPERAND_MSB = 12;
    localparam int OPERAND_LSB = 0;

    localparam logic [12:0] ROM_BASE = 13'h0000;
    localparam logic [12:0] ROM_LAST = 13'h17FF;
    localparam logic [12:0] RAM_BASE = 13'h1800;
    localparam logic [12:0] RAM_LAST = 13'h1FFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        FETCH_LO = 3'd2,
        EXEC     = 3'd3,
        HALT     = 3'd4
    } fsm_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC1 = 2'd1,
        PC_INC2 = 2'd2,
        PC_LOAD = 2'd3
    } pc_op_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: hold, +1, +2 or load, all modulo 2^ADDR_W.
module pc_counter #(
    parameter int                ADDR_W   = risc_cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  risc_cpu_pkg::pc_op_t op,
    input  logic [ADDR_W-1:0]    load_value,
    output logic [ADDR_W-1:0]    pc
);
    import risc_cpu_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            case (op)
                PC_INC1: pc <= pc + ADDR_W'(1);
                PC_INC2: pc <= pc + ADDR_W'(2);
                PC_LOAD: pc <= load_value;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_addr_gen.sv
// Instruction fetch sequencer: fetches a 16-bit instruction as two bytes,
// presents the operand address during EXEC and updates the PC on exec_done.
module fetch_addr_gen #(
    parameter int                ADDR_W   = risc_cpu_pkg::ADDR_W,
    parameter int                DATA_W   = risc_cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(13'h0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] data,
    input  logic              exec_done,
    input  logic              jump,
    input  logic              skip,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic [15:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    import risc_cpu_pkg::*;

    fsm_state_t state, state_nxt;
    pc_op_t     pc_op;
    logic       load_hi, load_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flags are only honoured on the exec_done edge; halt_req outranks jump outranks skip.
    always_comb begin
        state_nxt = state;
        pc_op     = PC_HOLD;
        load_hi   = 1'b0;
        load_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (ena) state_nxt = FETCH_HI;
            end
            FETCH_HI: begin
                load_hi   = 1'b1;
                pc_op     = PC_INC1;
                state_nxt = FETCH_LO;
            end
            FETCH_LO: begin
                load_lo   = 1'b1;
                pc_op     = PC_INC1;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    if (halt_req) begin
                        state_nxt = HALT;
                    end else begin
                        if (jump)      pc_op = PC_LOAD;
                        else if (skip) pc_op = PC_INC2;
                        state_nxt = ena ? FETCH_HI : IDLE;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
        end else begin
            if (load_hi) ir[15:8] <= data;
            if (load_lo) ir[7:0]  <= data;
            ir_valid <= load_lo;
        end
    end

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (pc_op),
        .load_value (ADDR_W'(ir[OPERAND_MSB:OPERAND_LSB])),
        .pc         (pc)
    );

    // Outputs decode from registered state only, so no input reaches them combinationally.
    assign addr   = (state == EXEC) ? ADDR_W'(ir[OPERAND_MSB:OPERAND_LSB]) : pc;
    assign rd     = (state == FETCH_HI) || (state == FETCH_LO);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Bench for fetch_addr_gen: an instruction-level model of fetch/exec driven by
// randomized memory contents and flags, plus directed corner scenarios.
module tb_fetch_addr_gen;

    localparam logic [12:0] RPC = 13'h0000;

    logic        clk, rst_n, ena, exec_done, jump, skip, halt_req;
    logic [7:0]  data;
    logic [12:0] addr;
    logic        rd;
    logic [15:0] ir;
    logic        ir_valid;
    logic [12:0] pc;
    logic        halted;

    logic [7:0]  mem [0:8191];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          pc_m;
    logic [15:0] ir_m;

    fetch_addr_gen #(
        .ADDR_W   (13),
        .DATA_W   (8),
        .RESET_PC (RPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data      (data),
        .exec_done (exec_done),
        .jump      (jump),
        .skip      (skip),
        .halt_req  (halt_req),
        .addr      (addr),
        .rd        (rd),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .halted    (halted)
    );

    assign data = mem[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $error("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [12:0] a13(input int x);
        return 13'(x % 8192);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plant(input logic [7:0] hi, input logic [7:0] lo);
        mem[a13(pc_m)]     = hi;
        mem[a13(pc_m + 1)] = lo;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, 32'(addr), 32'(RPC));
        chk({tag, "_rd"}, 32'(rd), 32'd0);
        chk({tag, "_ir"}, 32'(ir), 32'd0);
        chk({tag, "_irv"}, 32'(ir_valid), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'(RPC));
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    // Entered in the first FETCH_HI cycle; leaves in the next FETCH_HI cycle unless halting.
    task automatic do_instr(input bit j, input bit s, input bit h, input bit ena_after,
                            input bit drop_ena, input bit rst_mid);
        int n;
        ir_m = {mem[a13(pc_m)], mem[a13(pc_m + 1)]};
        chk("fhi_addr", 32'(addr), 32'(a13(pc_m)));
        chk("fhi_rd", 32'(rd), 32'd1);
        chk("fhi_irv", 32'(ir_valid), 32'd0);
        ena = 1'($urandom_range(0, 1));
        tick();
        chk("flo_addr", 32'(addr), 32'(a13(pc_m + 1)));
        chk("flo_rd", 32'(rd), 32'd1);
        chk("flo_pc", 32'(pc), 32'(a13(pc_m + 1)));
        if (drop_ena) ena = 1'b0;
        if (rst_mid) begin
            #2 rst_n = 1'b0;
            #1;
            chk_reset("async_rst");
            tick();
            chk_reset("rst_hold");
            rst_n = 1'b1;
            ena   = 1'b1;
            pc_m  = int'(RPC);
            tick();
            return;
        end
        tick();
        pc_m = int'(a13(pc_m + 2));
        chk("exec_ir", 32'(ir), 32'(ir_m));
        chk("exec_irv", 32'(ir_valid), 32'd1);
        chk("exec_addr", 32'(addr), 32'(ir_m[12:0]));
        chk("exec_rd", 32'(rd), 32'd0);
        chk("exec_pc", 32'(pc), 32'(pc_m));
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            exec_done = 1'b0;
            jump      = 1'($urandom_range(0, 1));
            skip      = 1'($urandom_range(0, 1));
            halt_req  = 1'($urandom_range(0, 1));
            ena       = 1'($urandom_range(0, 1));
            tick();
            chk("hold_irv", 32'(ir_valid), 32'd0);
            chk("hold_ir", 32'(ir), 32'(ir_m));
            chk("hold_pc", 32'(pc), 32'(pc_m));
            chk("hold_addr", 32'(addr), 32'(ir_m[12:0]));
        end
        exec_done = 1'b1;
        jump      = j;
        skip      = s;
        halt_req  = h;
        ena       = ena_after;
        tick();
        exec_done = 1'b0;
        jump      = 1'b0;
        skip      = 1'b0;
        halt_req  = 1'b0;
        if (h) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_pc", 32'(pc), 32'(pc_m));
            return;
        end
        if (j)      pc_m = int'(ir_m[12:0]);
        else if (s) pc_m = int'(a13(pc_m + 2));
        if (!ena_after) begin
            chk("idle_rd", 32'(rd), 32'd0);
            chk("idle_addr", 32'(addr), 32'(pc_m));
            chk("idle_pc", 32'(pc), 32'(pc_m));
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                tick();
                chk("idle_stay_rd", 32'(rd), 32'd0);
                chk("idle_stay_addr", 32'(addr), 32'(pc_m));
            end
            ena = 1'b1;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA0;
        mem[1] = 8'h12;
        mem[2] = 8'hE3;
        mem[3] = 8'h45;
        rst_n = 1'b1; ena = 1'b0; exec_done = 1'b0;
        jump = 1'b0; skip = 1'b0; halt_req = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_reset("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_ena_rd", 32'(rd), 32'd0);
        chk("idle_no_ena_addr", 32'(addr), 32'(RPC));
        ena  = 1'b1;
        pc_m = int'(RPC);
        tick();

        // straight fetch of 0xA012 from address 0
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("straight_ir", 32'(ir), 32'h0000_A012);
        chk("straight_pc", 32'(pc), 32'd2);

        // jump via 0xE345
        do_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("jump_pc", 32'(pc), 32'h345);
        chk("jump_fetch_addr", 32'(addr), 32'h345);

        for (int k = 0; k < 30; k++) begin
            do_instr(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'b0,
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'b0);
        end

        // skip across the top of the address space
        plant(8'h1F, 8'hFC);
        do_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_instr(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_skip_pc", 32'(pc), 32'd0);

        // fetch straddling 0x1FFF -> 0x0000
        plant(8'h1F, 8'hFF);
        do_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_fetch_start", 32'(addr), 32'h1FFF);
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_fetch_pc", 32'(pc), 32'd1);

        // ena dropped during FETCH_LO, then resume from IDLE
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset in the middle of FETCH_LO
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("restart_addr", 32'(addr), 32'(RPC));
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // all flags together: halt wins
        do_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ena       = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            jump      = 1'($urandom_range(0, 1));
            skip      = 1'($urandom_range(0, 1));
            halt_req  = 1'($urandom_range(0, 1));
            tick();
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_rd", 32'(rd), 32'd0);
            chk("halt_pc_stay", 32'(pc), 32'(pc_m));
            chk("halt_addr", 32'(addr), 32'(pc_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
